id_ex_reg: RTL and testbench

ID/EX pipeline register for the MIPS-subset pipelined processor. It sits directly downstream of the ID-stage control decoder and register file, and registers their outputs into the EX stage. It resolves the destination register and extends the immediate at capture time. It detects load-use hazards against the instruction in EX and inserts bubbles on hazard or flush. It also keeps a saturating bubble counter for performance monitoring.

---
 rtl/id_ex_reg_if.sv | 38 +++
 rtl/id_ex_reg.sv | 115 +++++++++++
 tb/tb_id_ex_reg.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bus: ID-stage decoder/regfile outputs in,
// registered EX-stage fields, stall and bubble counter out.
interface id_ex_reg_if #(parameter int CNT_W = 16);
  // pipeline control
  logic             hold;
  logic             flush;
  // decoder controls
  logic             RegDst, MemReg, RegW, MemW, Branch, ExtOp;
  logic [1:0]       ALUsrc, ALUop;
  // ID data and instruction fields
  logic [31:0]      id_pc4, id_rs_data, id_rt_data;
  logic [15:0]      id_imm;
  logic [4:0]       id_rs, id_rt, id_rd, id_shamt;
  // EX-stage registered outputs
  logic             ex_MemReg, ex_RegW, ex_MemW, ex_Branch;
  logic [1:0]       ex_ALUsrc, ex_ALUop;
  logic [31:0]      ex_pc4, ex_rs_data, ex_rt_data, ex_imm32;
  logic [4:0]       ex_rs, ex_rt, ex_wreg, ex_shamt;
  logic             ex_valid;
  logic             stall;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output hold, flush, RegDst, MemReg, RegW, MemW, Branch, ExtOp, ALUsrc, ALUop,
           id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_shamt,
    input  ex_MemReg, ex_RegW, ex_MemW, ex_Branch, ex_ALUsrc, ex_ALUop,
           ex_pc4, ex_rs_data, ex_rt_data, ex_imm32, ex_rs, ex_rt, ex_wreg, ex_shamt,
           ex_valid, stall, bubble_cnt
  );

  modport slave (
    input  hold, flush, RegDst, MemReg, RegW, MemW, Branch, ExtOp, ALUsrc, ALUop,
           id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_shamt,
    output ex_MemReg, ex_RegW, ex_MemW, ex_Branch, ex_ALUsrc, ex_ALUop,
           ex_pc4, ex_rs_data, ex_rt_data, ex_imm32, ex_rs, ex_rt, ex_wreg, ex_shamt,
           ex_valid, stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Resolves the destination register and extends
// the immediate at capture, inserts bubbles on flush or load-use hazard,
// and keeps a saturating bubble counter.
// Optional feature macro: LOAD_USE_STALL_EN (load-use hazard detection).
module id_ex_reg #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  id_ex_reg_if.slave  bus
);

  typedef struct packed {
    logic        MemReg;
    logic        RegW;
    logic        MemW;
    logic        Branch;
    logic [1:0]  ALUsrc;
    logic [1:0]  ALUop;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm32;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic [4:0]  shamt;
    logic        valid;
  } ex_t;

  ex_t              ex_q, ex_d, ld;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;
  logic             bubble;

  // Capture transforms applied to the ID instruction on a normal load.
  always_comb begin
    ld         = '0;
    ld.MemReg  = bus.MemReg;
    ld.RegW    = bus.RegW;
    ld.MemW    = bus.MemW;
    ld.Branch  = bus.Branch;
    ld.ALUsrc  = bus.ALUsrc;
    ld.ALUop   = bus.ALUop;
    ld.pc4     = bus.id_pc4;
    ld.rs_data = bus.id_rs_data;
    ld.rt_data = bus.id_rt_data;
    ld.imm32   = bus.ExtOp ? {{16{bus.id_imm[15]}}, bus.id_imm} : {16'h0000, bus.id_imm};
    ld.rs      = bus.id_rs;
    ld.rt      = bus.id_rt;
    ld.wreg    = bus.RegDst ? bus.id_rd : bus.id_rt;
    ld.shamt   = bus.id_shamt;
    ld.valid   = 1'b1;
  end

`ifdef LOAD_USE_STALL_EN
  // Load in EX whose destination (never $zero) is a source of the ID instruction.
  // rt only counts as a source for R-type, stores and branches.
  always_comb begin
    hz = ex_q.valid & ex_q.MemReg & ex_q.RegW & (ex_q.wreg != 5'd0) &
         ((ex_q.wreg == bus.id_rs) |
          ((ex_q.wreg == bus.id_rt) & (bus.RegDst | bus.MemW | bus.Branch)));
  end
`else
  // Load delay slots are scheduled by software; no hazard detection.
  assign hz = 1'b0;
`endif

  assign bus.stall = hz & ~bus.hold & ~bus.flush;
  // flush and hz together still make a single bubble
  assign bubble    = ~bus.hold & (bus.flush | hz);

  // Next state: hold freezes everything, else bubble, else load.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (!bus.hold) begin
      if (bubble) begin
        ex_d = '0;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ex_d = ld;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_MemReg  = ex_q.MemReg;
  assign bus.ex_RegW    = ex_q.RegW;
  assign bus.ex_MemW    = ex_q.MemW;
  assign bus.ex_Branch  = ex_q.Branch;
  assign bus.ex_ALUsrc  = ex_q.ALUsrc;
  assign bus.ex_ALUop   = ex_q.ALUop;
  assign bus.ex_pc4     = ex_q.pc4;
  assign bus.ex_rs_data = ex_q.rs_data;
  assign bus.ex_rt_data = ex_q.rt_data;
  assign bus.ex_imm32   = ex_q.imm32;
  assign bus.ex_rs      = ex_q.rs;
  assign bus.ex_rt      = ex_q.rt;
  assign bus.ex_wreg    = ex_q.wreg;
  assign bus.ex_shamt   = ex_q.shamt;
  assign bus.ex_valid   = ex_q.valid;
  assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: table of capture vectors, hand-written
// hazard/priority/saturation sequences, then randomized traffic against a
// behavioural model of the EX slot.
module tb_id_ex_reg;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef LOAD_USE_STALL_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  id_ex_reg_if #(.CNT_W(CNT_W)) b ();
  id_ex_reg #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic RegDst, MemReg, RegW, MemW, Branch, ExtOp;
    logic [1:0] ALUsrc, ALUop;
    logic [31:0] pc4, rsd, rtd;
    logic [15:0] imm;
    logic [4:0] rs, rt, rd, shamt;
  } in_t;

  typedef struct packed {
    logic MemReg, RegW, MemW, Branch;
    logic [1:0] ALUsrc, ALUop;
    logic [31:0] pc4, rsd, rtd, imm32;
    logic [4:0] rs, rt, wreg, shamt;
    logic valid;
  } exp_t;

  typedef struct {
    in_t         in;
    logic [4:0]  e_wreg;
    logic [31:0] e_imm;
    logic        e_regw;
  } vec_t;

  exp_t m;
  int   mcnt;
  int   n_chk, n_fail;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic in_t mkin(input bit regdst, input bit extop, input bit regw,
                               input bit memreg, input bit memw,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [15:0] imm);
    in_t v;
    v.RegDst = regdst; v.ExtOp = extop; v.RegW = regw; v.MemReg = memreg;
    v.MemW = memw; v.Branch = 1'b0;
    v.ALUsrc = {1'b0, ~regdst}; v.ALUop = regdst ? 2'b10 : 2'b00;
    v.pc4 = 32'h0040_0000 + {16'h0, imm};
    v.rsd = 32'hA500_0000 | {27'h0, rs};
    v.rtd = 32'h5A00_0000 | {27'h0, rt};
    v.imm = imm; v.rs = rs; v.rt = rt; v.rd = rd; v.shamt = imm[10:6];
    return v;
  endfunction

  task automatic apply(input in_t v);
    b.RegDst = v.RegDst; b.MemReg = v.MemReg; b.RegW = v.RegW; b.MemW = v.MemW;
    b.Branch = v.Branch; b.ExtOp = v.ExtOp; b.ALUsrc = v.ALUsrc; b.ALUop = v.ALUop;
    b.id_pc4 = v.pc4; b.id_rs_data = v.rsd; b.id_rt_data = v.rtd; b.id_imm = v.imm;
    b.id_rs = v.rs; b.id_rt = v.rt; b.id_rd = v.rd; b.id_shamt = v.shamt;
  endtask

  // Hazard from the model's view of the EX slot and the current ID inputs.
  function automatic bit model_hz();
    bit reads_rt, hit;
    reads_rt = b.RegDst || b.MemW || b.Branch;
    hit = (m.wreg == b.id_rs) || (reads_rt && m.wreg == b.id_rt);
    return HZ_EN && m.valid && m.MemReg && m.RegW && (m.wreg != 0) && hit;
  endfunction

  task automatic model_update();
    bit h;
    h = model_hz();
    if (rst) begin
      m = '0; mcnt = 0;
    end else if (b.hold) begin
      // frozen
    end else if (b.flush || h) begin
      m = '0;
      mcnt = (mcnt + 1 > CMAX) ? CMAX : mcnt + 1;
    end else begin
      m.MemReg = b.MemReg; m.RegW = b.RegW; m.MemW = b.MemW; m.Branch = b.Branch;
      m.ALUsrc = b.ALUsrc; m.ALUop = b.ALUop;
      m.pc4 = b.id_pc4; m.rsd = b.id_rs_data; m.rtd = b.id_rt_data;
      m.imm32 = b.ExtOp ? 32'(int'($signed(b.id_imm))) : 32'(int'(b.id_imm));
      m.rs = b.id_rs; m.rt = b.id_rt; m.shamt = b.id_shamt;
      m.wreg = b.RegDst ? b.id_rd : b.id_rt;
      m.valid = 1'b1;
    end
  endtask

  task automatic check_all();
    check("ex_MemReg", b.ex_MemReg, m.MemReg);
    check("ex_RegW", b.ex_RegW, m.RegW);
    check("ex_MemW", b.ex_MemW, m.MemW);
    check("ex_Branch", b.ex_Branch, m.Branch);
    check("ex_ALUsrc", b.ex_ALUsrc, m.ALUsrc);
    check("ex_ALUop", b.ex_ALUop, m.ALUop);
    check("ex_pc4", b.ex_pc4, m.pc4);
    check("ex_rs_data", b.ex_rs_data, m.rsd);
    check("ex_rt_data", b.ex_rt_data, m.rtd);
    check("ex_imm32", b.ex_imm32, m.imm32);
    check("ex_rs", b.ex_rs, m.rs);
    check("ex_rt", b.ex_rt, m.rt);
    check("ex_wreg", b.ex_wreg, m.wreg);
    check("ex_shamt", b.ex_shamt, m.shamt);
    check("ex_valid", b.ex_valid, m.valid);
    check("bubble_cnt", b.bubble_cnt, mcnt);
  endtask

  // One clock: check combinational stall, advance DUT and model, compare.
  task automatic tick();
    if (!rst) check("stall", b.stall, model_hz() && !b.hold && !b.flush);
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  vec_t vt[5];
  in_t  lw5, add5, v;
  int   c0;

  initial begin
    n_chk = 0; n_fail = 0; m = '0; mcnt = 0;
    vt[0] = '{mkin(0,1,1,0,0, 5'd9, 5'd8, 5'd0, 16'hFFFC), 5'd8, 32'hFFFF_FFFC, 1'b1};
    vt[1] = '{mkin(0,0,1,0,0, 5'd9, 5'd8, 5'd0, 16'hFFFC), 5'd8, 32'h0000_FFFC, 1'b1};
    vt[2] = '{mkin(1,1,1,0,0, 5'd5, 5'd2, 5'd3, 16'h1820), 5'd3, 32'h0000_1820, 1'b1};
    vt[3] = '{mkin(0,0,1,0,0, 5'd1, 5'd4, 5'd17, 16'h8001), 5'd4, 32'h0000_8001, 1'b1};
    vt[4] = '{mkin(0,1,0,0,1, 5'd6, 5'd7, 5'd31, 16'h8000), 5'd7, 32'hFFFF_8000, 1'b0};
    lw5  = mkin(0,1,1,1,0, 5'd4, 5'd5, 5'd0, 16'h0010);
    add5 = mkin(1,0,1,0,0, 5'd5, 5'd2, 5'd3, 16'h1820);

    // reset with nonzero inputs
    rst = 1'b1; b.hold = 1'b0; b.flush = 1'b0;
    apply(lw5);
    tick(); tick();
    check("rst_cnt", b.bubble_cnt, 0);
    check("rst_valid", b.ex_valid, 0);
    rst = 1'b0;
    check("stall_after_rst", b.stall, 0);

    // capture transforms
    for (int i = 0; i < 5; i++) begin
      apply(vt[i].in);
      tick();
      check("tbl_wreg", b.ex_wreg, vt[i].e_wreg);
      check("tbl_imm32", b.ex_imm32, vt[i].e_imm);
      check("tbl_RegW", b.ex_RegW, vt[i].e_regw);
      check("tbl_valid", b.ex_valid, 1);
    end

    // load-use: lw $5 then add $3,$5,$2
    apply(lw5); tick();
    c0 = mcnt;
    apply(add5);
    check("lu_stall", b.stall, HZ_EN);
    tick();
    check("lu_bubble_valid", b.ex_valid, !HZ_EN);
    check("lu_cnt", b.bubble_cnt, c0 + int'(HZ_EN));
    check("lu_stall_drop", b.stall, 0);
    tick();
    check("lu_add_valid", b.ex_valid, 1);
    check("lu_add_wreg", b.ex_wreg, 3);

    // load to $zero never stalls
    apply(mkin(0,1,1,1,0, 5'd4, 5'd0, 5'd0, 16'h0004)); tick();
    c0 = mcnt;
    apply(mkin(1,0,1,0,0, 5'd0, 5'd0, 5'd6, 16'h3020));
    check("zero_stall", b.stall, 0);
    tick();
    check("zero_valid", b.ex_valid, 1);
    check("zero_cnt", b.bubble_cnt, c0);

    // hold with flush is ignored; release with flush bubbles once
    apply(vt[0].in); tick();
    c0 = mcnt;
    b.hold = 1'b1; b.flush = 1'b1;
    apply(vt[2].in);
    tick(); tick();
    check("hold_wreg", b.ex_wreg, 8);
    check("hold_cnt", b.bubble_cnt, c0);
    check("hold_stall", b.stall, 0);
    b.hold = 1'b0;
    tick();
    check("hold_rel_valid", b.ex_valid, 0);
    check("hold_rel_cnt", b.bubble_cnt, c0 + 1);
    b.flush = 1'b0;

    // flush and load-use together: one bubble, +1
    apply(lw5); tick();
    c0 = mcnt;
    apply(add5); b.flush = 1'b1;
    check("fh_stall", b.stall, 0);
    tick();
    check("fh_cnt", b.bubble_cnt, c0 + 1);
    check("fh_valid", b.ex_valid, 0);
    b.flush = 1'b0;

    // reset mid-operation drops in-flight instruction, no bubble counted
    apply(lw5); tick();
    apply(add5); rst = 1'b1;
    tick();
    check("rst_mid_cnt", b.bubble_cnt, 0);
    check("rst_mid_valid", b.ex_valid, 0);
    rst = 1'b0;

    // saturation
    b.flush = 1'b1;
    for (int i = 0; i < CMAX + 5; i++) tick();
    check("sat_cnt", b.bubble_cnt, CMAX);
    b.flush = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      v = mkin($urandom_range(1,0), $urandom_range(1,0), $urandom_range(1,0),
               $urandom_range(1,0), $urandom_range(1,0),
               5'($urandom_range(3,0)), 5'($urandom_range(3,0)),
               5'($urandom_range(3,0)), 16'($urandom));
      v.Branch = ($urandom_range(3,0) == 0);
      v.rsd = $urandom; v.rtd = $urandom; v.pc4 = $urandom;
      apply(v);
      rst     = ($urandom_range(63,0) == 0);
      b.hold  = ($urandom_range(7,0) == 0);
      b.flush = ($urandom_range(7,0) == 0);
      tick();
    end
    rst = 1'b0; b.hold = 1'b0; b.flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
